// File: rtl/mod7879_pkg.sv
// mod7879_pkg: shared constants and types for the mod-7879 packing path.
//   NTRU_Q / NTRU_QH : modulus and half-modulus of the centered residues
//   COEF_W / BYTE_W  : coefficient field width and output byte width
//   ACC_W            : packer bit accumulator width (7 leftover bits + 13 new)
//   state_t          : packer frame state
package mod7879_pkg;

  localparam int NTRU_Q  = 7879;
  localparam int NTRU_QH = 3939;

  localparam int COEF_W = 13;
  localparam int BYTE_W = 8;
  localparam int ACC_W  = 20;

  typedef enum logic {
    ACCEPT = 1'b0,
    DRAIN  = 1'b1
  } state_t;

endpackage

// File: rtl/mod7879_pack13_if.sv
// mod7879_pack13_if: stream bundle around the 13-bit packer.
//   in_valid/in_ready/in_data      : coefficient input handshake
//   out_valid/out_ready/out_data   : packed byte output handshake
//   out_last                       : marks the final byte of a frame
//   err                            : sticky out-of-range flag
// slave is the packer's view, master the view of the surrounding logic.
interface mod7879_pack13_if;
  import mod7879_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [COEF_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [BYTE_W-1:0] out_data;
  logic              out_last;
  logic              err;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, err
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, err
  );

endinterface

// File: rtl/mod7879_pack13_lift_u.sv
// mod7879_lift_u: maps a 13-bit signed centered residue onto the unsigned
// code range 0..7878, folding one modulus in either direction.
//   i_x         : signed residue, any 13-bit value
//   o_u         : x' + 3939, where x' is x folded into -3939..3939
//   o_range_err : x was outside -3939..3939 and needed folding
module mod7879_lift_u
  import mod7879_pkg::*;
(
  input  logic signed [COEF_W-1:0] i_x,
  output logic        [COEF_W-1:0] o_u,
  output logic                     o_range_err
);

  localparam logic signed [COEF_W-1:0] QH_S = COEF_W'(NTRU_QH);
  localparam logic        [COEF_W-1:0] QH_U = COEF_W'(NTRU_QH);
  localparam logic        [COEF_W-1:0] Q_U  = COEF_W'(NTRU_Q);

  logic [COEF_W-1:0] w_x_fix;

  // The fold and the offset are done modulo 2^13: the true results always
  // land inside the 13-bit range, so the wrap never loses information.
  always_comb begin
    w_x_fix     = i_x;
    o_range_err = 1'b0;
    if (i_x > QH_S) begin
      w_x_fix     = i_x - Q_U;
      o_range_err = 1'b1;
    end else if (i_x < -QH_S) begin
      w_x_fix     = i_x + Q_U;
      o_range_err = 1'b1;
    end
    o_u = w_x_fix + QH_U;
  end

endmodule

// File: rtl/mod7879_pack13.sv
// mod7879_pack13: packs centered mod-7879 residues as 13-bit LSB-first fields
// into a byte stream, one frame of N coefficients at a time.
//   clk   : clock, rising edge
//   Reset : synchronous, active-high
//   bus   : slave view of mod7879_pack13_if (coefficient in, byte out,
//           out_last on the final byte of each frame, sticky err)
//
// state  | meaning
// -------+--------------------------------------------------------------
// ACCEPT | taking coefficients while fewer than 8 bits are buffered,
//        | otherwise emitting full bytes
// DRAIN  | whole frame accepted; flush buffered bits, zero-padding the
//        | final byte, which carries out_last
module mod7879_pack13
  import mod7879_pkg::*;
#(
  parameter int N = 1277
) (
  input logic             clk,
  input logic             Reset,
  mod7879_pack13_if.slave bus
);

  localparam int            KW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST   = KW'(N - 1);
  localparam logic [4:0]    CNT_BYTE = 5'(BYTE_W);
  localparam logic [4:0]    CNT_COEF = 5'(COEF_W);

  state_t             r_state, w_state_nxt;
  logic [ACC_W-1:0]   r_acc, w_acc_nxt;
  logic [4:0]         r_cnt, w_cnt_nxt;
  logic [KW-1:0]      r_k, w_k_nxt;
  logic               r_in_ready, w_in_ready_nxt;
  logic               r_out_valid, w_out_valid_nxt;
  logic [BYTE_W-1:0]  r_out_data, w_out_data_nxt;
  logic               r_out_last, w_out_last_nxt;
  logic               r_err, w_err_nxt;

  logic [COEF_W-1:0]  w_u;
  logic               w_range_err;
  logic               w_accept;
  logic               w_out_free;

  mod7879_lift_u u_lift (
    .i_x         (bus.in_data),
    .o_u         (w_u),
    .o_range_err (w_range_err)
  );

  // Bits above cnt in the accumulator are always zero, so new fields can be
  // OR-ed in and the final DRAIN byte comes out zero-padded for free.
  always_comb begin
    w_accept        = bus.in_valid && r_in_ready;
    w_out_free      = !r_out_valid || bus.out_ready;

    w_state_nxt     = r_state;
    w_acc_nxt       = r_acc;
    w_cnt_nxt       = r_cnt;
    w_k_nxt         = r_k;
    w_out_valid_nxt = r_out_valid && !bus.out_ready;
    w_out_data_nxt  = r_out_data;
    w_out_last_nxt  = r_out_last;
    w_err_nxt       = r_err || (w_accept && w_range_err);

    case (r_state)
      ACCEPT: begin
        if (w_accept) begin
          w_acc_nxt = r_acc | (ACC_W'(w_u) << r_cnt);
          w_cnt_nxt = r_cnt + CNT_COEF;
          if (r_k == K_LAST) begin
            w_state_nxt = DRAIN;
          end else begin
            w_k_nxt = r_k + 1'b1;
          end
        end else if ((r_cnt >= CNT_BYTE) && w_out_free) begin
          w_out_valid_nxt = 1'b1;
          w_out_data_nxt  = r_acc[BYTE_W-1:0];
          w_out_last_nxt  = 1'b0;
          w_acc_nxt       = r_acc >> BYTE_W;
          w_cnt_nxt       = r_cnt - CNT_BYTE;
        end
      end

      DRAIN: begin
        if ((r_cnt != 5'd0) && w_out_free) begin
          w_out_valid_nxt = 1'b1;
          w_out_data_nxt  = r_acc[BYTE_W-1:0];
          if (r_cnt > CNT_BYTE) begin
            w_out_last_nxt = 1'b0;
            w_acc_nxt      = r_acc >> BYTE_W;
            w_cnt_nxt      = r_cnt - CNT_BYTE;
          end else begin
            // This byte holds the frame's last data bit.
            w_out_last_nxt = 1'b1;
            w_acc_nxt      = '0;
            w_cnt_nxt      = 5'd0;
            w_k_nxt        = '0;
            w_state_nxt    = ACCEPT;
          end
        end
      end

      default: begin
        w_state_nxt = ACCEPT;
      end
    endcase

    // in_ready is registered from the next-cycle state so the first accept of
    // a new frame can follow the out_last load immediately.
    w_in_ready_nxt = (w_state_nxt == ACCEPT) && (w_cnt_nxt < CNT_BYTE);
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state     <= ACCEPT;
      r_acc       <= '0;
      r_cnt       <= 5'd0;
      r_k         <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_k         <= w_k_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_last  <= w_out_last_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_mod7879_pack13.sv
// tb_mod7879_pack13: scoreboard bench for mod7879_pack13. Four instances
// (N = 1, 2, 8, 1277) share one driver; sel routes stimulus and the monitor
// to one of them. Expected bytes come from a bit-queue model of the frame.
module tb_mod7879_pack13;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        Reset;
  int          sel;
  logic        drv_valid;
  logic [12:0] drv_data;
  logic        drv_oready = 1'b1;
  int          rdy_mode;          // 0: ready high, 1: random, 2: held low

  int n_of [4] = '{1, 2, 8, 1277};

  mod7879_pack13_if if_a ();
  mod7879_pack13_if if_b ();
  mod7879_pack13_if if_c ();
  mod7879_pack13_if if_d ();

  mod7879_pack13 #(.N(1))    u_n1    (.clk(clk), .Reset(Reset), .bus(if_a));
  mod7879_pack13 #(.N(2))    u_n2    (.clk(clk), .Reset(Reset), .bus(if_b));
  mod7879_pack13 #(.N(8))    u_n8    (.clk(clk), .Reset(Reset), .bus(if_c));
  mod7879_pack13 #(.N(1277)) u_n1277 (.clk(clk), .Reset(Reset), .bus(if_d));

  assign if_a.in_valid  = drv_valid && (sel == 0);
  assign if_b.in_valid  = drv_valid && (sel == 1);
  assign if_c.in_valid  = drv_valid && (sel == 2);
  assign if_d.in_valid  = drv_valid && (sel == 3);
  assign if_a.in_data   = drv_data;
  assign if_b.in_data   = drv_data;
  assign if_c.in_data   = drv_data;
  assign if_d.in_data   = drv_data;
  assign if_a.out_ready = (sel == 0) ? drv_oready : 1'b1;
  assign if_b.out_ready = (sel == 1) ? drv_oready : 1'b1;
  assign if_c.out_ready = (sel == 2) ? drv_oready : 1'b1;
  assign if_d.out_ready = (sel == 3) ? drv_oready : 1'b1;

  logic [3:0] w_ir, w_ov, w_ol, w_er;
  logic [7:0] w_od [4];
  assign w_ir = {if_d.in_ready,  if_c.in_ready,  if_b.in_ready,  if_a.in_ready};
  assign w_ov = {if_d.out_valid, if_c.out_valid, if_b.out_valid, if_a.out_valid};
  assign w_ol = {if_d.out_last,  if_c.out_last,  if_b.out_last,  if_a.out_last};
  assign w_er = {if_d.err,       if_c.err,       if_b.err,       if_a.err};
  assign w_od[0] = if_a.out_data;
  assign w_od[1] = if_b.out_data;
  assign w_od[2] = if_c.out_data;
  assign w_od[3] = if_d.out_data;

  logic       mon_in_ready, mon_out_valid, mon_last, mon_err;
  logic [7:0] mon_data;
  always_comb begin
    mon_in_ready  = w_ir[sel[1:0]];
    mon_out_valid = w_ov[sel[1:0]];
    mon_last      = w_ol[sel[1:0]];
    mon_err       = w_er[sel[1:0]];
    mon_data      = w_od[sel[1:0]];
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit         bitq [$];
  logic [8:0] expq [$];
  int         mk;
  bit         m_err;

  task automatic model_push(input int x);
    int         u;
    bit         final_c;
    logic [7:0] b;
    u = ((x + 3939) % 7879 + 7879) % 7879;
    if (x > 3939 || x < -3939) m_err = 1'b1;
    for (int i = 0; i < 13; i++) bitq.push_back(u[i]);
    mk++;
    final_c = (mk == n_of[sel]);
    if (final_c) mk = 0;
    while (bitq.size() >= 8 || (final_c && bitq.size() > 0)) begin
      b = '0;
      for (int j = 0; j < 8; j++) if (bitq.size() > 0) b[j] = bitq.pop_front();
      expq.push_back({final_c && (bitq.size() == 0), b});
    end
  endtask

  // ---------------- ready pattern ----------------
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      1:       drv_oready = ($urandom_range(0, 4) != 0);
      2:       drv_oready = 1'b0;
      default: drv_oready = 1'b1;
    endcase
  end

  // ---------------- monitor / scoreboard ----------------
  bit         stall_hold = 1'b0;
  logic [7:0] held_data;
  logic       held_last;
  int         frame_cnt = 0;
  logic [8:0] exp_b;

  always @(negedge clk) begin
    if (Reset) begin
      stall_hold = 1'b0;
      frame_cnt  = 0;
    end else begin
      if (stall_hold)
        chk("stall_hold", {mon_out_valid, mon_last, mon_data}, {1'b1, held_last, held_data});
      if (mon_out_valid && drv_oready) begin
        stall_hold = 1'b0;
        frame_cnt++;
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_byte actual=0x%0h expected=none", {mon_last, mon_data});
        end else begin
          exp_b = expq.pop_front();
          chk("byte", {mon_last, mon_data}, exp_b);
        end
        if (mon_last) begin
          chk("frame_len", frame_cnt, (n_of[sel] * 13 + 7) / 8);
          frame_cnt = 0;
        end
      end else if (mon_out_valid) begin
        stall_hold = 1'b1;
        held_data  = mon_data;
        held_last  = mon_last;
      end else begin
        stall_hold = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int x);
    int guard;
    guard     = 0;
    drv_valid = 1'b1;
    drv_data  = 13'(x);
    model_push(x);
    forever begin
      @(negedge clk);
      if (mon_in_ready) break;
      guard++;
      if (guard > 500) begin
        chk("accept_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    drv_valid = 1'b0;
  endtask

  task automatic do_reset(input int new_sel, input bit chk_en);
    Reset     = 1'b1;
    drv_valid = 1'b0;
    sel       = new_sel;
    expq.delete();
    bitq.delete();
    mk    = 0;
    m_err = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    if (chk_en) begin
      chk("rst_in_ready",  mon_in_ready,  0);
      chk("rst_out_valid", mon_out_valid, 0);
      chk("rst_out_data",  mon_data,      0);
      chk("rst_out_last",  mon_last,      0);
      chk("rst_err",       mon_err,       0);
    end
    @(posedge clk);
    #1;
    Reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    if (chk_en) chk("post_rst_in_ready", mon_in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((expq.size() != 0 || mon_out_valid) && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20000) chk("drain_timeout", expq.size(), 0);
    chk("err_flag", mon_err, m_err);
    @(posedge clk);
    #1;
  endtask

  function automatic int s13(input int r);
    logic signed [12:0] t;
    t = r[12:0];
    return int'(t);
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    int  guard;
    bit  bad;
    Reset     = 1'b1;
    drv_valid = 1'b0;
    drv_data  = '0;
    sel       = 0;
    rdy_mode  = 0;
    mk        = 0;
    m_err     = 1'b0;

    do_reset(0, 1'b1);

    // N=1, x=0 with latency check
    send(0);
    @(negedge clk);
    chk("latency_t1", mon_out_valid, 0);
    @(negedge clk);
    chk("latency_t2", mon_out_valid, 1);
    @(posedge clk);
    #1;
    wait_idle();

    // N=8, all -3939, in_ready low through DRAIN
    do_reset(2, 1'b0);
    for (int i = 0; i < 8; i++) send(-3939);
    bad   = 1'b0;
    guard = 0;
    forever begin
      @(negedge clk);
      if (mon_out_valid && mon_last) break;
      if (mon_in_ready) bad = 1'b1;
      guard++;
      if (guard > 100) begin
        bad = 1'b1;
        break;
      end
    end
    chk("drain_in_ready", bad, 0);
    @(posedge clk);
    #1;
    wait_idle();

    // N=2, both inputs out of range
    do_reset(1, 1'b0);
    chk("err_before", mon_err, 0);
    send(4000);
    chk("err_after_first", mon_err, 1);
    send(-4000);
    wait_idle();

    // N=8 random in range, output stalled mid-frame
    do_reset(2, 1'b0);
    fork
      begin
        for (int i = 0; i < 8; i++) send(int'($urandom_range(0, 7878)) - 3939);
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        rdy_mode = 2;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("stall_in_ready", mon_in_ready, 0);
        @(posedge clk);
        #1;
        rdy_mode = 0;
      end
    join
    wait_idle();

    // reset mid-frame after 3 coefficients, then fresh frames
    do_reset(2, 1'b0);
    for (int i = 0; i < 3; i++) send(int'($urandom_range(0, 7878)) - 3939);
    do_reset(2, 1'b1);
    for (int i = 0; i < 8; i++) send(int'($urandom_range(0, 7878)) - 3939);
    wait_idle();
    do_reset(0, 1'b0);
    send(0);
    wait_idle();

    // default N, full-range random residues, two back-to-back frames
    do_reset(3, 1'b0);
    rdy_mode = 1;
    for (int i = 0; i < 2 * 1277; i++) send(s13(int'($urandom_range(0, 8191))));
    wait_idle();
    rdy_mode = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog expired at t=%0t checks=%0d failures=%0d", $time, checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mod7879_pack13.md
# mod7879_pack13

Streaming packer on the output side of the mod-7879 reduction pipeline. It accepts centered signed residues (nominally −3939..3939) and maps each to an unsigned code 0..7878. It packs the codes LSB-first as 13-bit fields into a byte stream, one frame of N coefficients at a time, using valid/ready handshakes on both sides. Its output feeds the byte-oriented transport and storage path for Rq polynomials (q = 7879).

## Interface

Parameters:
- N, default 1277: coefficients per frame (≥1).

Ports:
- clk  in  1  clock; all logic on rising edge.
- Reset  in  1  reset; synchronous, active-high.
- in_valid  in  1  in_data holds a coefficient.
- in_ready  out  1  packer accepts in_data this cycle.
- in_data  in  13  signed centered residue.
- out_valid  out  1  out_data holds a byte.
- out_ready  in  1  downstream accepts out_data this cycle.
- out_data  out  8  packed byte.
- out_last  out  1  qualifies the final byte of a frame.
- err  out  1  sticky flag: an out-of-range coefficient was seen.

## Operation

- Accept: `in_valid && in_ready`.
  - in_ready = (state == ACCEPT) && (cnt < 8), a registered function only.
- Lift: start from the 13-bit signed input x.
  - If x > 3939, x' = x − 7879.
  - If x < −3939, x' = x + 7879.
  - Otherwise x' = x.
  - Any correction sets err.
  - u = x' + 3939, always 0..7878.
  - One correction covers the full −4096..4095 input range.
- Accumulator acc is 20 bits; cnt is 0..20. On accept, u is written at bit offset cnt and cnt += 13.
- Byte extraction happens when cnt ≥ 8 and the output register is free (`!out_valid || out_ready`).
  - The output register loads acc[7:0].
  - acc shifts right 8 and cnt −= 8.
  - Extraction and accept are mutually exclusive: accept needs cnt < 8, extraction needs cnt ≥ 8.
- Coefficient counter k runs 0..N−1 and counts accepts. Accepting coefficient N−1 moves the state to DRAIN.
- State ACCEPT: accept and extract as above.
- State DRAIN: in_ready = 0.
  - Extract while cnt ≥ 8.
  - If 0 < cnt < 8, emit one final byte with its upper bits zero-padded; cnt → 0.
  - The byte that carries the last data bit has out_last = 1.
  - After that byte loads, state → ACCEPT and k → 0.
- Frame length is ceil(13N/8) bytes. For N = 1277 this is 2076 bytes, with 7 pad bits.
- Output register: out_data and out_last stay stable while `out_valid && !out_ready`.
- err is cleared only by Reset. It is not cleared at frame boundaries.

## Timing

- Reset values:
  - in_ready = 0 during reset, 1 in the first cycle after.
  - out_valid = 0, out_data = 0, out_last = 0, err = 0.
  - acc = 0, cnt = 0, k = 0, state = ACCEPT.
- Reset mid-frame discards every buffered bit and any pending output byte. The next coefficient starts a new frame.
- Latency: a coefficient accepted in cycle t with cnt = 0 produces out_valid in cycle t+2, with out_ready high.
- err rises in the cycle after the offending accept.
- Throughput: one accept or one extraction per cycle.
  - With no stalls, 8 coefficients take 21 cycles (8 accepts + 13 byte loads).
- Backpressure: a stalled output register blocks extraction. cnt stays ≥ 8, so in_ready falls and no data is lost.
- Frame turnaround: the first accept of the next frame can occur in the cycle after the out_last byte loads.

## Structure

- Shared package mod7879_pkg holds:
  - NTRU_Q = 7879, NTRU_QH = 3939.
  - COEF_W = 13, BYTE_W = 8, ACC_W = 20.
  - The state enum {ACCEPT, DRAIN}.
- Sub-module mod7879_lift_u (combinational): 13-bit signed in → 13-bit u plus a range-error bit. It is reused by the matching unpacker's range check.
- Top level holds the accumulator, counters, FSM and output register.

## Test plan

- N=1, x=0 → u=0x0F63 → bytes 0x63 and then 0x0F; out_last on the second byte; err=0.
- N=8, all x=−3939 → 13 bytes of 0x00; out_last only on byte 13; in_ready never high during DRAIN.
- N=2, x0=4000, x1=−4000:
  - u0 = 60 (0x3C), u1 = 7818 (0x1E8A); err rises after the first accept.
  - Bytes: 0x3C, 0x40, 0xD1, 0x03 (last).
- N=8, random in-range values, out_ready held low for 5 cycles mid-frame:
  - out_data/out_last stable throughout the stall; in_ready low once cnt ≥ 8.
  - Byte stream matches the reference model bit-exactly.
- Reset asserted mid-frame after 3 coefficients:
  - All outputs at reset values the next cycle.
  - A following full N=1 frame with x=0 yields 0x63, 0x0F.
- Default N=1277, random residues:
  - Exactly 2076 bytes; out_last only on byte 2076; top 7 bits of that byte are 0.
  - Back-to-back second frame correct.
